mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data RAM of the von Neumann configuration between instruction fetch (IF) and the load/store path of the mem stage. It issues word-aligned RAM accesses, routes read data back to the owning requester, and sequences sub-word stores (SB/SH) as read-modify-write. A starvation counter bounds fetch latency. It sits between the if/mem stages and the RAM macro.

## Interface
- ADDR_W, 32, address width (matches `PORT_ADDR_WIDTH)
- DATA_W, 32, data width (matches `PORT_DATA_WIDTH)
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced priority (1..15)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on clk)
- if_req_i  in  1  fetch request, held until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- ls_req_i  in  1  load/store request, held until granted
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  byte address
- ls_be_i  in  4  byte enables, lane k = bits [8k+7:8k]
- ls_wdata_i  in  DATA_W  store data, already lane-aligned
- ls_gnt_o  out  1  load/store accepted
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  DATA_W  raw load word (mem stage extracts/extends)
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write
- ram_addr_o  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- ram_wdata_o  out  DATA_W  write word
- ram_be_o  out  4  RAM byte-write enables
- ram_rdata_i  in  DATA_W  read data, valid one cycle after ram_en_o & !ram_we_o

## Operation
- FSM states: IDLE, RMW_RD, RMW_WR.
- IDLE arbitration per cycle: LS beats IF, unless starve_cnt == STARVE_MAX and if_req_i, then IF wins. Exactly one grant per issued access.
- starve_cnt: +1 (saturating at STARVE_MAX) each cycle if_req_i is high and IF not granted; cleared when IF granted or if_req_i low.
- Read (IF, or LS with ls_we_i=0): ram_en_o=1, ram_we_o=0, gnt pulses same cycle; owner flop records destination; next cycle the owner's rvalid=1, rdata=ram_rdata_i. Back-to-back reads issue every cycle.
- Full store (ls_be_i=4'hF): single cycle, ram_we_o=1, ram_be_o=4'hF, ls_gnt_o same cycle. Stay IDLE.
- Partial store (ls_be_i != 4'hF, != 0): IDLE→RMW_RD issues read of word, no gnt; RMW_RD→RMW_WR... (RMW_RD is the read-issue cycle; RMW_WR is the next cycle): merge ram_rdata_i with ls_wdata_i lane-wise per ls_be_i, write with ram_be_o=4'hF, ls_gnt_o=1, return to IDLE. No IF grant during RMW; starve_cnt keeps counting.
- ls_be_i=0 store: granted, no RAM write (ram_en_o=0).
- rvalid outputs never asserted for stores.
- rdata outputs hold last value when rvalid low.

## Timing
- Reset: FSM=IDLE, starve_cnt=0, owner=none; all outputs 0 (gnt, rvalid, ram_en_o, ram_we_o, ram_be_o, addresses, data).
- Read latency: gnt at cycle N, rvalid at N+1.
- Partial store: 2 cycles, gnt at N+1; requester must hold ls_* stable N..N+1.
- Reset mid-RMW: write abandoned, no RAM write, next cycle IDLE; pending rvalid suppressed.
- Simultaneous requests with starve_cnt < STARVE_MAX: LS granted, IF waits.
- Request dropped before grant: no access, no error.

## Configuration
- MEM_ARB_RMW_EN defined: partial stores use RMW as above; ram_be_o always 4'hF on writes.
- Undefined: partial stores single cycle, ram_be_o=ls_be_i, ram_wdata_o=ls_wdata_i, ls_gnt_o same cycle; RMW states unreachable and removed.

## Structure
- define.v additions: state encodings `ARB_IDLE/`ARB_RMW_RD/`ARB_RMW_WR, owner codes `ARB_OWN_NONE/`ARB_OWN_IF/`ARB_OWN_LS.
- Sub-module byte_merge (combinational: old word, new word, be → merged word), instantiated only under MEM_ARB_RMW_EN.

## Test plan
- Reset then IF read 0x100, RAM[0x100]=0x12345678 → if_gnt_o cycle N, if_rvalid_o & if_rdata_o=0x12345678 at N+1.
- IF and LS load both requesting for 6 cycles, STARVE_MAX=4 → LS granted 4 cycles, IF granted 5th, LS 6th.
- SB to 0x202 (be=4'b0100, wdata=0x00AB0000), RAM[0x200]=0x11223344, RMW enabled → read at N, write 0x11AB3344 at N+1, ls_gnt_o at N+1.
- Same SB with macro undefined → single write cycle, ram_be_o=4'b0100, gnt at N.
- Reset asserted in RMW_RD → no write, RAM[0x200] unchanged, all outputs 0 next cycle.
- SW 0xDEADBEEF to 0x300 then LW 0x300 back-to-back → write N, read N+1, ls_rdata_o=0xDEADBEEF at N+2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM state and read-owner encodings, lane constants
// and the fetch starvation counter update.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RMW_RD = 2'd1,
    ARB_RMW_WR = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ARB_OWN_NONE = 2'd0,
    ARB_OWN_IF   = 2'd1,
    ARB_OWN_LS   = 2'd2
  } arb_owner_e;

  localparam int         BE_W     = 4;
  localparam int         LANE_W   = 8;
  localparam int         STARVE_W = 4;
  localparam logic [3:0] BE_FULL  = 4'hF;
  localparam logic [3:0] BE_NONE  = 4'h0;

  // Saturating count of consecutive denied fetch cycles; any non-waiting cycle clears it.
  function automatic logic [STARVE_W-1:0] starve_next(input logic [STARVE_W-1:0] cnt,
                                                      input logic [STARVE_W-1:0] lim,
                                                      input logic            waiting);
    logic [STARVE_W-1:0] res;
    if (!waiting) begin
      res = {STARVE_W{1'b0}};
    end else if (cnt < lim) begin
      res = cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
    end else begin
      res = lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the RAM macro.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [BE_W-1:0]   ram_be_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i, ram_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i, ram_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
  );

endinterface

// File: rtl/mem_port_arbiter_byte_merge.sv
// Lane-wise merge of a store word into the word read back from RAM.
// Only exists when MEM_ARB_RMW_EN is defined (read-modify-write sub-word stores).
`ifdef MEM_ARB_RMW_EN
module mem_port_arbiter_byte_merge
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);

  // Enabled lanes take the store byte, the rest keep the RAM byte.
  always_comb begin
    merged = old_word;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) begin
        merged[LANE_W*k +: LANE_W] = new_word[LANE_W*k +: LANE_W];
      end else begin
        merged[LANE_W*k +: LANE_W] = old_word[LANE_W*k +: LANE_W];
      end
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store with starvation bound.
// MEM_ARB_RMW_EN selects read-modify-write sub-word stores. rst_n is an active-HIGH sync reset.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_r, state_next_s, phase_s;
  arb_owner_e          owner_r, owner_next_s;
  logic [STARVE_W-1:0] starve_r;
  logic [DATA_W-1:0]   if_hold_r, ls_hold_r;
  logic                if_win_s, ls_win_s, ls_partial_s;
  logic                if_gnt_s, ls_gnt_s, ram_en_s, ram_we_s;
  logic [BE_W-1:0]     ram_be_s;
  logic [ADDR_W-1:0]   ram_addr_s, if_word_s, ls_word_s;
  logic [DATA_W-1:0]   ram_wdata_s;
  logic                unused_addr_bits_s;

  assign if_word_s          = {bus.if_addr_i[ADDR_W-1:2], 2'b00};
  assign ls_word_s          = {bus.ls_addr_i[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits_s = ^{bus.if_addr_i[1:0], bus.ls_addr_i[1:0]};
  assign ls_partial_s       = bus.ls_we_i && (bus.ls_be_i != BE_FULL) && (bus.ls_be_i != BE_NONE);

  // Idle-cycle arbitration: load/store wins unless fetch has hit the starvation limit.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (state_r == ARB_IDLE) begin
      if_win_s = bus.if_req_i && (!bus.ls_req_i || (starve_r == STARVE_LIM));
      ls_win_s = bus.ls_req_i && !if_win_s;
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

`ifdef MEM_ARB_RMW_EN
  logic [DATA_W-1:0] merged_s;

  mem_port_arbiter_byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
    .old_word (bus.ram_rdata_i),
    .new_word (bus.ls_wdata_i),
    .be       (bus.ls_be_i),
    .merged   (merged_s)
  );

  // The read half of a partial store is issued from IDLE in the same cycle it wins.
  assign phase_s = (ls_win_s && ls_partial_s) ? ARB_RMW_RD : state_r;
`else
  assign phase_s = state_r;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = ARB_IDLE;
    case (phase_s)
      ARB_IDLE:   state_next_s = ARB_IDLE;
`ifdef MEM_ARB_RMW_EN
      ARB_RMW_RD: state_next_s = ARB_RMW_WR;
      ARB_RMW_WR: state_next_s = ARB_IDLE;
`endif
      default:    state_next_s = ARB_IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is asserted.
  always_comb begin
    if_gnt_s     = 1'b0;
    ls_gnt_s     = 1'b0;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_be_s     = BE_NONE;
    ram_addr_s   = {ADDR_W{1'b0}};
    ram_wdata_s  = {DATA_W{1'b0}};
    owner_next_s = ARB_OWN_NONE;
    if (rst_n) begin
      owner_next_s = ARB_OWN_NONE;
    end else begin
      case (phase_s)
        ARB_IDLE: begin
          if (if_win_s) begin
            if_gnt_s     = 1'b1;
            ram_en_s     = 1'b1;
            ram_addr_s   = if_word_s;
            owner_next_s = ARB_OWN_IF;
          end else if (ls_win_s) begin
            ls_gnt_s   = 1'b1;
            ram_addr_s = ls_word_s;
            if (!bus.ls_we_i) begin
              ram_en_s     = 1'b1;
              owner_next_s = ARB_OWN_LS;
            end else if (bus.ls_be_i != BE_NONE) begin
              ram_en_s    = 1'b1;
              ram_we_s    = 1'b1;
              ram_be_s    = bus.ls_be_i;
              ram_wdata_s = bus.ls_wdata_i;
            end else begin
              ram_en_s = 1'b0;
            end
          end else begin
            ram_en_s = 1'b0;
          end
        end
`ifdef MEM_ARB_RMW_EN
        ARB_RMW_RD: begin
          ram_en_s   = 1'b1;
          ram_addr_s = ls_word_s;
        end
        ARB_RMW_WR: begin
          ls_gnt_s    = 1'b1;
          ram_en_s    = 1'b1;
          ram_we_s    = 1'b1;
          ram_be_s    = BE_FULL;
          ram_addr_s  = ls_word_s;
          ram_wdata_s = merged_s;
        end
`endif
        default: ram_en_s = 1'b0;
      endcase
    end
  end

  // Read owner, starvation counter and held read data.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      owner_r   <= ARB_OWN_NONE;
      starve_r  <= {STARVE_W{1'b0}};
      if_hold_r <= {DATA_W{1'b0}};
      ls_hold_r <= {DATA_W{1'b0}};
    end else begin
      owner_r  <= owner_next_s;
      starve_r <= starve_next(starve_r, STARVE_LIM, bus.if_req_i && !if_gnt_s);
      if (owner_r == ARB_OWN_IF) begin
        if_hold_r <= bus.ram_rdata_i;
      end else begin
        if_hold_r <= if_hold_r;
      end
      if (owner_r == ARB_OWN_LS) begin
        ls_hold_r <= bus.ram_rdata_i;
      end else begin
        ls_hold_r <= ls_hold_r;
      end
    end
  end

  assign bus.if_gnt_o    = if_gnt_s;
  assign bus.ls_gnt_o    = ls_gnt_s;
  assign bus.ram_en_o    = ram_en_s;
  assign bus.ram_we_o    = ram_we_s;
  assign bus.ram_be_o    = ram_be_s;
  assign bus.ram_addr_o  = ram_addr_s;
  assign bus.ram_wdata_o = ram_wdata_s;
  assign bus.if_rvalid_o = !rst_n && (owner_r == ARB_OWN_IF);
  assign bus.ls_rvalid_o = !rst_n && (owner_r == ARB_OWN_LS);
  assign bus.if_rdata_o  = rst_n ? {DATA_W{1'b0}} :
                           ((owner_r == ARB_OWN_IF) ? bus.ram_rdata_i : if_hold_r);
  assign bus.ls_rdata_o  = rst_n ? {DATA_W{1'b0}} :
                           ((owner_r == ARB_OWN_LS) ? bus.ram_rdata_i : ls_hold_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios, then randomized traffic checked by a
// scoreboard against a word-array reference memory. Honours MEM_ARB_RMW_EN.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_RMW_EN
  localparam bit RMW_BUILD = 1'b1;
`else
  localparam bit RMW_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // RAM macro model: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int k = 0; k < 4; k++)
          if (bus.ram_be_o[k]) mem[bus.ram_addr_o[11:2]][8*k +: 8] <= bus.ram_wdata_o[8*k +: 8];
      end else begin
        bus.ram_rdata_i <= mem[bus.ram_addr_o[11:2]];
      end
    end
  end

  // Scoreboard monitor: every read-data beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (bus.if_rvalid_o) begin
        if (if_q.size() == 0) chk("if_rvalid_orphan", {31'd0, bus.if_rvalid_o}, 32'd0);
        else chk("sb_if_rdata", bus.if_rdata_o, if_q.pop_front());
      end
      if (bus.ls_rvalid_o) begin
        if (ls_q.size() == 0) chk("ls_rvalid_orphan", {31'd0, bus.ls_rvalid_o}, 32'd0);
        else chk("sb_ls_rdata", bus.ls_rdata_o, ls_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 32'd0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_addr_i  = 32'd0;
    bus.ls_be_i    = 4'h0;
    bus.ls_wdata_i = 32'd0;
  endtask

  task automatic ls_drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = we;
    bus.ls_addr_i  = addr;
    bus.ls_be_i    = be;
    bus.ls_wdata_i = wdata;
  endtask

  initial begin
    bit          if_pend, ls_pend, rmw_second, rmw_next, exp_if, exp_ls, if_req_now;
    int          wait_c, diffs;
    logic [31:0] if_a, ls_a, ls_d;
    logic [3:0]  ls_b;
    logic        ls_w;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
    bus.ram_rdata_i = 32'd0;
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Requests during reset are ignored and every output stays low.
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    ls_drive(1'b1, 32'h104, 4'hF, 32'hFFFF_FFFF);
    #1;
    chk("rst_if_gnt", {31'd0, bus.if_gnt_o}, 32'd0);
    chk("rst_ls_gnt", {31'd0, bus.ls_gnt_o}, 32'd0);
    chk("rst_ram_en", {31'd0, bus.ram_en_o}, 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we_o}, 32'd0);
    chk("rst_ram_addr", bus.ram_addr_o, 32'd0);
    chk("rst_ram_be", {28'd0, bus.ram_be_o}, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata_o, 32'd0);
    chk("rst_rvalid", {30'd0, bus.if_rvalid_o, bus.ls_rvalid_o}, 32'd0);
    chk("rst_rdata", bus.if_rdata_o | bus.ls_rdata_o, 32'd0);
    @(negedge clk); idle_inputs(); rst_n = 1'b0;
    #1; chk("idle_ram_en", {31'd0, bus.ram_en_o}, 32'd0);
    chk("rst_no_write", mem[65], 32'hC0DE0041);

    // Fetch read: grant at N, data at N+1, held afterwards.
    mem[64] = 32'h12345678;
    @(negedge clk); bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; #1;
    chk("t1_if_gnt", {31'd0, bus.if_gnt_o}, 32'd1);
    chk("t1_ram_en_we", {30'd0, bus.ram_en_o, bus.ram_we_o}, 32'd2);
    chk("t1_ram_addr", bus.ram_addr_o, 32'h100);
    @(negedge clk); bus.if_req_i = 1'b0; #1;
    chk("t1_if_rvalid", {31'd0, bus.if_rvalid_o}, 32'd1);
    chk("t1_if_rdata", bus.if_rdata_o, 32'h12345678);
    chk("t1_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd0);
    @(negedge clk); #1;
    chk("t1_rvalid_drop", {31'd0, bus.if_rvalid_o}, 32'd0);
    chk("t1_rdata_hold", bus.if_rdata_o, 32'h12345678);

    // Both requesting: LS four times, IF on the fifth, LS on the sixth.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
      ls_drive(1'b0, 32'h108, 4'hF, 32'd0);
      #1;
      chk($sformatf("t2_if_gnt_c%0d", i), {31'd0, bus.if_gnt_o}, {31'd0, (i == 4)});
      chk($sformatf("t2_ls_gnt_c%0d", i), {31'd0, bus.ls_gnt_o}, {31'd0, (i != 4)});
    end
    @(negedge clk); idle_inputs();

    // SB 0x202 into 0x11223344.
    mem[128] = 32'h11223344;
    @(negedge clk); ls_drive(1'b1, 32'h202, 4'b0100, 32'h00AB0000); #1;
`ifdef MEM_ARB_RMW_EN
    chk("t3_rd_en_we", {30'd0, bus.ram_en_o, bus.ram_we_o}, 32'd2);
    chk("t3_rd_addr", bus.ram_addr_o, 32'h200);
    chk("t3_rd_gnt", {31'd0, bus.ls_gnt_o}, 32'd0);
    @(negedge clk); #1;
    chk("t3_wr_we", {31'd0, bus.ram_we_o}, 32'd1);
    chk("t3_wr_be", {28'd0, bus.ram_be_o}, 32'hF);
    chk("t3_wr_data", bus.ram_wdata_o, 32'h11AB3344);
`else
    chk("t3_wr_we", {31'd0, bus.ram_we_o}, 32'd1);
    chk("t3_wr_be", {28'd0, bus.ram_be_o}, 32'h4);
    chk("t3_wr_data", bus.ram_wdata_o, 32'h00AB0000);
`endif
    chk("t3_wr_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
    chk("t3_wr_addr", bus.ram_addr_o, 32'h200);
    @(negedge clk); idle_inputs(); #1;
    chk("t3_ram_word", mem[128], 32'h11AB3344);
    chk("t3_no_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd0);

    // Reset during a partial store abandons the write.
    mem[128] = 32'h11223344;
    @(negedge clk); ls_drive(1'b1, 32'h202, 4'b0100, 32'h00AB0000);
`ifdef MEM_ARB_RMW_EN
    #1; chk("t4_rd_issue", {31'd0, bus.ram_en_o}, 32'd1);
    @(negedge clk);
`endif
    rst_n = 1'b1; #1;
    chk("t4_rst_en_we", {30'd0, bus.ram_en_o, bus.ram_we_o}, 32'd0);
    chk("t4_rst_gnt", {31'd0, bus.ls_gnt_o}, 32'd0);
    chk("t4_rst_wdata", bus.ram_wdata_o, 32'd0);
    @(negedge clk); rst_n = 1'b0; idle_inputs(); #1;
    chk("t4_after_en", {31'd0, bus.ram_en_o}, 32'd0);
    chk("t4_mem_unchanged", mem[128], 32'h11223344);
    @(negedge clk); ls_drive(1'b0, 32'h200, 4'hF, 32'd0); #1;
    chk("t4_idle_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
    @(negedge clk); idle_inputs(); rst_n = 1'b1; #1;
    chk("t4_rvalid_suppressed", {31'd0, bus.ls_rvalid_o}, 32'd0);
    chk("t4_rdata_zero", bus.ls_rdata_o, 32'd0);

    // SW then LW back-to-back.
    @(negedge clk); rst_n = 1'b0; ls_drive(1'b1, 32'h300, 4'hF, 32'hDEADBEEF); #1;
    chk("t5_sw_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
    chk("t5_sw_we_be", {27'd0, bus.ram_we_o, bus.ram_be_o}, 32'h1F);
    chk("t5_sw_data", bus.ram_wdata_o, 32'hDEADBEEF);
    @(negedge clk); bus.ls_we_i = 1'b0; #1;
    chk("t5_lw_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
    chk("t5_lw_en_we", {30'd0, bus.ram_en_o, bus.ram_we_o}, 32'd2);
    @(negedge clk); idle_inputs(); #1;
    chk("t5_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd1);
    chk("t5_ls_rdata", bus.ls_rdata_o, 32'hDEADBEEF);

    // Store with no byte enables: granted, no RAM access.
    @(negedge clk); ls_drive(1'b1, 32'h300, 4'h0, 32'h0BAD0BAD); #1;
    chk("t6_gnt", {31'd0, bus.ls_gnt_o}, 32'd1);
    chk("t6_ram_en", {31'd0, bus.ram_en_o}, 32'd0);
    @(negedge clk); idle_inputs(); #1;
    chk("t6_no_rvalid", {31'd0, bus.ls_rvalid_o}, 32'd0);
    chk("t6_mem_kept", mem[192], 32'hDEADBEEF);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h5A000000 ^ (i * 32'h00010203);
      ref_mem[i] = 32'h5A000000 ^ (i * 32'h00010203);
    end
    @(negedge clk);
    mon_en = 1'b1;
    if_pend = 1'b0; ls_pend = 1'b0; rmw_second = 1'b0; wait_c = 0;
    if_a = 32'd0; ls_a = 32'd0; ls_d = 32'd0; ls_b = 4'h0; ls_w = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (if_pend && $urandom_range(0, 9) == 0) begin
        if_pend = 1'b0;
      end else if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1;
        if_a    = 32'h400 + $urandom_range(0, 63) * 4;
      end
      if (!ls_pend && $urandom_range(0, 1) == 1) begin
        ls_pend = 1'b1;
        ls_w    = 1'($urandom_range(0, 1));
        ls_a    = 32'h400 + $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
        ls_d    = $urandom;
        case ($urandom_range(0, 5))
          0, 1:    ls_b = 4'hF;
          2:       ls_b = 4'h0;
          default: ls_b = 4'($urandom_range(1, 14));
        endcase
      end
      bus.if_req_i = if_pend; bus.if_addr_i = if_a;
      if (ls_pend) ls_drive(ls_w, ls_a, ls_b, ls_d);
      else bus.ls_req_i = 1'b0;

      rmw_next = 1'b0;
      if (rmw_second) begin
        exp_if = 1'b0; exp_ls = 1'b1;
      end else begin
        exp_if = if_pend && (!ls_pend || wait_c >= STARVE_MAX);
        exp_ls = ls_pend && !exp_if;
        if (exp_ls && RMW_BUILD && ls_w && ls_b != 4'hF && ls_b != 4'h0) begin
          exp_ls = 1'b0; rmw_next = 1'b1;
        end
      end
      #1;
      chk("rnd_if_gnt", {31'd0, bus.if_gnt_o}, {31'd0, exp_if});
      chk("rnd_ls_gnt", {31'd0, bus.ls_gnt_o}, {31'd0, exp_ls});
      if_req_now = if_pend;
      if (exp_if) begin
        chk("rnd_if_addr", bus.ram_addr_o, if_a);
        if_q.push_back(ref_mem[if_a[11:2]]);
        if_pend = 1'b0;
      end
      if (exp_ls) begin
        if (!ls_w) ls_q.push_back(ref_mem[ls_a[11:2]]);
        else for (int k = 0; k < 4; k++)
          if (ls_b[k]) ref_mem[ls_a[11:2]][8*k +: 8] = ls_d[8*k +: 8];
        ls_pend = 1'b0;
      end
      if (if_req_now && !exp_if) wait_c = (wait_c < STARVE_MAX) ? wait_c + 1 : STARVE_MAX;
      else wait_c = 0;
      rmw_second = rmw_next;
    end
    @(negedge clk); idle_inputs();
    repeat (3) @(negedge clk);
    chk("sb_if_drained", if_q.size(), 32'd0);
    chk("sb_ls_drained", ls_q.size(), 32'd0);
    diffs = 0;
    for (int i = 256; i < 320; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("ram_image_diffs", diffs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
